// File: rtl/jt1942_dwnld.sv
// jt1942_dwnld: download router in front of jt1942_game.
// Splits the ioctl byte stream by address. ROM bytes become masked 16-bit SDRAM
// writes with a 1-deep pending buffer. PROM bytes become one-cycle write pulses.
// Optional feature macro: JT1942_DWNLD_CHK_EN (running byte checksum on chksum).
module jt1942_dwnld #(
    parameter logic [21:0] PROM_START = 22'h3A000,
    parameter int          PROM_NUM   = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ioctl_dwnld,
    input  logic                ioctl_wr,
    input  logic [21:0]         ioctl_addr,
    input  logic [7:0]          ioctl_data,
    output logic [21:0]         sdram_addr,
    output logic [15:0]         sdram_data,
    output logic [1:0]          sdram_mask,
    output logic                sdram_we,
    input  logic                sdram_rdy,
    output logic [7:0]          prog_addr,
    output logic [3:0]          prog_din,
    output logic [PROM_NUM-1:0] prom_we,
    output logic                downloading,
    output logic                overflow,
    output logic [15:0]         chksum
);

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    localparam logic [21:0] PROM_SPAN = 22'(PROM_NUM * 256);
    localparam logic [PROM_NUM-1:0] PROM_ONE = {{(PROM_NUM-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [21:0]         r_addr;
    logic [15:0]         r_data;
    logic [1:0]          r_mask;
    logic                r_we;
    logic                r_pendValid;
    logic [21:0]         r_pendAddr;
    logic [15:0]         r_pendData;
    logic [1:0]          r_pendMask;
    logic                r_overflow;
    logic [7:0]          r_progAddr;
    logic [3:0]          r_progDin;
    logic [PROM_NUM-1:0] r_promWe;
    logic                r_downloading;
    logic                r_dwnldLast;

    logic [21:0]         w_off;
    logic                w_belowProm;
    logic                w_isRom;
    logic                w_isProm;
    logic [3:0]          w_promSel;
    logic [21:0]         w_romAddr;
    logic [15:0]         w_romData;
    logic [1:0]          w_romMask;
    logic                w_drop;
    logic                w_dwnldRise;

    // Address decode of the incoming byte
    assign w_off       = ioctl_addr - PROM_START;
    assign w_belowProm = ioctl_addr < PROM_START;
    assign w_isRom     = ioctl_wr && w_belowProm;
    assign w_isProm    = ioctl_wr && !w_belowProm && (w_off < PROM_SPAN);
    assign w_promSel   = w_off[11:8];
    assign w_romAddr   = {1'b0, ioctl_addr[21:1]};
    assign w_romData   = {ioctl_data, ioctl_data};
    assign w_romMask   = ioctl_addr[0] ? 2'b01 : 2'b10;
    assign w_drop      = w_isRom && (r_state == ST_REQ) && !sdram_rdy && r_pendValid;
    assign w_dwnldRise = ioctl_dwnld && !r_dwnldLast;

    // ROM path: SDRAM request FSM with a 1-deep pending buffer and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_we        <= 1'b0;
            r_pendValid <= 1'b0;
            r_pendAddr  <= '0;
            r_pendData  <= '0;
            r_pendMask  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_isRom) begin
                        r_addr  <= w_romAddr;
                        r_data  <= w_romData;
                        r_mask  <= w_romMask;
                        r_we    <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sdram_rdy) begin
                        if (r_pendValid) begin
                            r_addr <= r_pendAddr;
                            r_data <= r_pendData;
                            r_mask <= r_pendMask;
                            if (w_isRom) begin
                                r_pendAddr <= w_romAddr;
                                r_pendData <= w_romData;
                                r_pendMask <= w_romMask;
                            end else begin
                                r_pendValid <= 1'b0;
                            end
                        end else if (w_isRom) begin
                            r_addr <= w_romAddr;
                            r_data <= w_romData;
                            r_mask <= w_romMask;
                        end else begin
                            r_we    <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_isRom) begin
                        if (!r_pendValid) begin
                            r_pendValid <= 1'b1;
                            r_pendAddr  <= w_romAddr;
                            r_pendData  <= w_romData;
                            r_pendMask  <= w_romMask;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // PROM path: one-cycle one-hot write pulse with held address and nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_promWe   <= '0;
            r_progAddr <= '0;
            r_progDin  <= '0;
        end else begin
            r_promWe <= w_isProm ? (PROM_ONE << w_promSel) : '0;
            if (w_isProm) begin
                r_progAddr <= w_off[7:0];
                r_progDin  <= ioctl_data[3:0];
            end
        end
    end

    // Downloading flag: set on loader start, cleared once the loader stops and all writes retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwnldLast   <= 1'b0;
            r_downloading <= 1'b0;
        end else begin
            r_dwnldLast <= ioctl_dwnld;
            if (w_dwnldRise) begin
                r_downloading <= 1'b1;
            end else if (!ioctl_dwnld && (r_state == ST_IDLE) && !r_pendValid) begin
                r_downloading <= 1'b0;
            end
        end
    end

`ifdef JT1942_DWNLD_CHK_EN
    logic [15:0] r_chksum;
    logic [15:0] w_chkBase;

    assign w_chkBase = w_dwnldRise ? 16'h0 : r_chksum;

    // Running sum of every accepted byte, restarted when a download begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chksum <= '0;
        end else if (ioctl_wr && !w_drop) begin
            r_chksum <= w_chkBase + {8'h0, ioctl_data};
        end else begin
            r_chksum <= w_chkBase;
        end
    end

    assign chksum = r_chksum;
`else
    assign chksum = 16'h0;
`endif

    assign sdram_addr  = r_addr;
    assign sdram_data  = r_data;
    assign sdram_mask  = r_mask;
    assign sdram_we    = r_we;
    assign prog_addr   = r_progAddr;
    assign prog_din    = r_progDin;
    assign prom_we     = r_promWe;
    assign downloading = r_downloading;
    assign overflow    = r_overflow;

endmodule
